handshake_const_match_sink: RTL and testbench
=============================================

Name: handshake_const_match_sink

Overview:
- Receiving end of a constant-producer channel in the dataflow HDL.
- Consumes data tokens (data, valid, ready), compares each token against a compile-time constant, and emits one dataless control token per consumed token.
- Each control token carries a match flag.
- Decouples the two sides with a 2-slot elastic buffer, and keeps mismatch statistics for debug and self-checking circuits.

Parameters:
- DATA_WIDTH, 32, width of the ins data channel.
- CONST_VALUE, 32'h000000EE, expected token value; the low DATA_WIDTH bits are used.
- COUNT_WIDTH, 16, width of the mismatch counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ins  input  DATA_WIDTH  incoming token data.
- ins_valid  input  1  incoming token valid.
- ins_ready  output  1  block can accept a token this cycle.
- outs_valid  output  1  control token available.
- outs_ready  input  1  downstream consumes the control token.
- outs_match  output  1  head token matched CONST_VALUE; meaningful only when outs_valid=1.
- mismatch_count  output  COUNT_WIDTH  number of accepted mismatching tokens, saturating.
- mismatch_seen  output  1  sticky: at least one mismatch accepted since reset.

Behaviour:
- Reset (rst=0, asynchronous): occupancy=0, outs_valid=0, outs_match=0, mismatch_count=0, mismatch_seen=0, ins_ready=0 while rst is low.
- First rising edge after release: ins_ready=1.
- Handshakes:
  - Accept when ins_valid & ins_ready.
  - Emit when outs_valid & outs_ready.
  - ins_ready must not depend combinationally on ins_valid.
  - outs_valid must not depend combinationally on outs_ready.
- Storage:
  - 2-slot FIFO of 1-bit match flags: head/tail pointer plus 2-bit occupancy (0, 1, 2).
  - Match bit = (ins == CONST_VALUE[DATA_WIDTH-1:0]), computed at accept; the data word itself is not stored.
- Outputs and latency:
  - ins_ready = (occupancy < 2), registered.
  - outs_valid = (occupancy != 0).
  - outs_match = head flag.
  - A token accepted at edge N appears on outs_valid after edge N, i.e. 1-cycle latency; no combinational bypass.
  - Full throughput: 1 token/cycle sustained when outs_ready=1.
- Occupancy transitions:
  - accept only: +1.
  - emit only: -1.
  - both: unchanged; head advances and new flag is written at tail.
  - neither: hold.
- Boundary conditions:
  - Occupancy 2: ins_ready=0, so accept is impossible.
  - Occupancy 0: emit is impossible.
  - Pointers wrap modulo 2.
  - While outs_valid=1 and outs_ready=0, outs_match must stay stable.
- Statistics:
  - On accept with mismatch: mismatch_count += 1, saturating at 2^COUNT_WIDTH-1 (no wrap).
  - On the same edge, mismatch_seen is set and stays set until reset.
- Reset mid-operation: buffered tokens are discarded and counters cleared immediately; no token is emitted after rst falls.
- X-safety: ins is ignored when ins_valid=0, and counters do not change in that case.

Decomposition:
- Shared package:
  - occupancy constants: OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - helper function computing the saturating increment.
- One natural sub-module, handshake_flag_fifo2: 2-slot, 1-bit-wide elastic FIFO with valid/ready on both sides, async active-low reset.
- Top level adds the comparator and the statistics counters.

Test Plan:
- Reset: hold rst=0 with ins_valid=1 and ins=0xEE -> ins_ready=0, outs_valid=0, mismatch_count=0; one edge after release -> ins_ready=1.
- Streaming: 4 tokens 0xEE back-to-back with outs_ready=1 -> outs_valid high on cycles 1..4, outs_match=1 each, mismatch_count=0, no bubbles.
- Backpressure: outs_ready=0, send 0xEE then 0x12 -> after 2 accepts ins_ready=0 and a third token stalls; outs_match=1 held stable. Raise outs_ready -> flags 1 then 0 emitted in order; mismatch_count=1, mismatch_seen=1.
- Simultaneous events: occupancy 1 with accept and emit on the same edge -> occupancy stays 1 and the new flag becomes head.
- Saturation: COUNT_WIDTH=2, send 5 tokens of 0x00 -> mismatch_count reaches 3 and holds; mismatch_seen=1.
- Mid-operation reset: 2 tokens buffered, pulse rst=0 asynchronously between edges -> outs_valid falls immediately, counters=0; no stale token after release.

Source files
------------

// File: rtl/handshake_const_match_sink_pkg.sv
// Shared constants and helpers for the constant-match sink and its flag FIFO.
package handshake_const_match_sink_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_value;
    if (width >= 32'd64) begin
      max_value = {64{1'b1}};
    end else begin
      max_value = (64'd1 << width) - 64'd1;
    end
    if (value >= max_value) begin
      sat_inc = max_value;
    end else begin
      sat_inc = value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/handshake_flag_fifo2.sv
// Two-slot elastic FIFO of 1-bit flags with valid/ready on both sides.
module handshake_flag_fifo2
  import handshake_const_match_sink_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_flag,
  output logic out_valid,
  input  logic out_ready,
  output logic out_flag
);

  logic [1:0] occ;
  logic [1:0] occ_next;
  logic       head;
  logic       head_next;
  logic       tail;
  logic       tail_next;
  logic [1:0] flags;
  logic [1:0] flags_next;
  logic       ready;
  logic       ready_next;
  logic       push;
  logic       pop;

  assign push      = in_valid & ready;
  assign pop       = out_valid & out_ready;
  assign in_ready  = ready;
  assign out_valid = (occ != OCC_EMPTY);
  assign out_flag  = flags[head];

  // Next-state for occupancy, pointers, flag storage and the registered ready.
  always_comb begin
    occ_next   = occ;
    head_next  = head;
    tail_next  = tail;
    flags_next = flags;
    case ({push, pop})
      2'b10:   occ_next = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_next = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_next = occ;
    endcase
    if (pop) begin
      head_next = ~head;
    end else begin
      head_next = head;
    end
    if (push) begin
      tail_next         = ~tail;
      flags_next[tail]  = in_flag;
    end else begin
      tail_next  = tail;
      flags_next = flags;
    end
    // ready is a pure function of the next occupancy, never of in_valid directly
    ready_next = (occ_next != OCC_FULL);
  end

  // State register; ready stays low throughout reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ   <= OCC_EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
      flags <= 2'b00;
      ready <= 1'b0;
    end else begin
      occ   <= occ_next;
      head  <= head_next;
      tail  <= tail_next;
      flags <= flags_next;
      ready <= ready_next;
    end
  end

endmodule

// File: rtl/handshake_const_match_sink.sv
// Consumes data tokens, compares each with a constant and emits a match-flag control token;
// tracks a saturating mismatch count and a sticky mismatch flag.
module handshake_const_match_sink
  import handshake_const_match_sink_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH  = 32,
  parameter logic [31:0]     CONST_VALUE = 32'h000000EE,
  parameter int unsigned     COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic                   outs_match,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic                   mismatch_seen
);

  localparam logic [DATA_WIDTH-1:0] MATCH_VALUE = DATA_WIDTH'(CONST_VALUE);

  logic                   is_match;
  logic                   accept;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   seen_next;

  assign is_match = (ins == MATCH_VALUE);
  assign accept   = ins_valid & ins_ready;

  handshake_flag_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ins_valid),
    .in_ready  (ins_ready),
    .in_flag   (is_match),
    .out_valid (outs_valid),
    .out_ready (outs_ready),
    .out_flag  (outs_match)
  );

  // Statistics only move on an accepted mismatch, so ins is don't-care while ins_valid is low.
  always_comb begin
    count_next = mismatch_count;
    seen_next  = mismatch_seen;
    if (accept && !is_match) begin
      count_next = COUNT_WIDTH'(sat_inc(64'(mismatch_count), COUNT_WIDTH));
      seen_next  = 1'b1;
    end else begin
      count_next = mismatch_count;
      seen_next  = mismatch_seen;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_count <= {COUNT_WIDTH{1'b0}};
      mismatch_seen  <= 1'b0;
    end else begin
      mismatch_count <= count_next;
      mismatch_seen  <= seen_next;
    end
  end

endmodule

// File: tb/tb_handshake_const_match_sink.sv
// Randomized and directed bench for handshake_const_match_sink against a queue-based model.
module tb_handshake_const_match_sink;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        outs_valid;
  logic        outs_ready;
  logic        outs_match;
  logic [15:0] mismatch_count;
  logic        mismatch_seen;

  logic [31:0] s_ins;
  logic        s_ins_valid;
  logic        s_ins_ready;
  logic        s_outs_valid;
  logic        s_outs_ready;
  logic        s_outs_match;
  logic [1:0]  s_mismatch_count;
  logic        s_mismatch_seen;

  int total;
  int bad;

  // reference model of the main instance
  bit mq[$];
  int mcount;
  bit mseen;
  bit mready_ok;

  handshake_const_match_sink dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .outs_match(outs_match),
    .mismatch_count(mismatch_count), .mismatch_seen(mismatch_seen)
  );

  handshake_const_match_sink #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .ins(s_ins), .ins_valid(s_ins_valid), .ins_ready(s_ins_ready),
    .outs_valid(s_outs_valid), .outs_ready(s_outs_ready), .outs_match(s_outs_match),
    .mismatch_count(s_mismatch_count), .mismatch_seen(s_mismatch_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_ready();
    return mready_ok && (mq.size() < 2);
  endfunction

  function automatic bit model_head();
    return (mq.size() > 0) ? mq[0] : 1'b0;
  endfunction

  function automatic void model_clear();
    mq.delete();
    mcount = 0;
    mseen = 1'b0;
    mready_ok = 1'b0;
  endfunction

  // Drives one cycle from a negedge to the next negedge and advances the model.
  task automatic cycle(input bit v, input logic [31:0] d, input bit r);
    bit acc;
    bit emt;
    ins_valid = v;
    ins = d;
    outs_ready = r;
    acc = v && model_ready();
    emt = (mq.size() > 0) && r;
    @(posedge clk);
    if (emt) mq.pop_front();
    if (acc) begin
      mq.push_back(d == 32'h0000_00EE);
      if (d != 32'h0000_00EE) begin
        if (mcount < 65535) mcount++;
        mseen = 1'b1;
      end
    end
    mready_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ins_valid = 1'b1;
    ins = 32'h0000_00EE;
    outs_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ins_ready); end
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outs_valid); end
    total++; if (mismatch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", mismatch_count); end
    total++; if (mismatch_seen !== 1'b0) begin bad++; $display("FAIL reset_seen got=%b exp=0", mismatch_seen); end
    ins_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL release_ready_before_edge got=%b exp=0", ins_ready); end
    cycle(1'b0, 32'h0, 1'b1);
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL release_ready_after_edge got=%b exp=1", ins_ready); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h0000_00EE, 1'b1);
      total++; if (outs_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, outs_valid); end
      total++; if (outs_match !== 1'b1) begin bad++; $display("FAIL stream_match[%0d] got=%b exp=1", i, outs_match); end
      total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ins_ready); end
    end
    total++; if (mismatch_count !== 16'd0) begin bad++; $display("FAIL stream_count got=%0d exp=0", mismatch_count); end
    cycle(1'b0, 32'h0, 1'b1);
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", outs_valid); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 32'h0000_00EE, 1'b0);
    cycle(1'b1, 32'h0000_0012, 1'b0);
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", ins_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0000_0077, 1'b0);
      total++; if (outs_match !== 1'b1 || outs_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got valid=%b match=%b exp valid=1 match=1", i, outs_valid, outs_match);
      end
    end
    total++; if (mismatch_count !== 16'd1) begin bad++; $display("FAIL bp_stall_count got=%0d exp=1", mismatch_count); end
    cycle(1'b0, 32'h0, 1'b1);
    total++; if (outs_valid !== 1'b1 || outs_match !== 1'b0) begin
      bad++; $display("FAIL bp_second_flag got valid=%b match=%b exp valid=1 match=0", outs_valid, outs_match);
    end
    cycle(1'b0, 32'h0, 1'b1);
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", outs_valid); end
    total++; if (mismatch_count !== 16'd1 || mismatch_seen !== 1'b1) begin
      bad++; $display("FAIL bp_stats got count=%0d seen=%b exp count=1 seen=1", mismatch_count, mismatch_seen);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 32'h0000_00EE, 1'b0);
    cycle(1'b1, 32'h0000_0055, 1'b1);
    total++; if (outs_valid !== 1'b1 || outs_match !== 1'b0 || ins_ready !== 1'b1) begin
      bad++; $display("FAIL simul got valid=%b match=%b ready=%b exp valid=1 match=0 ready=1", outs_valid, outs_match, ins_ready);
    end
    cycle(1'b0, 32'h0, 1'b1);
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL simul_drain got=%b exp=0", outs_valid); end
  endtask

  task automatic test_random();
    bit v;
    bit r;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 1) == 0) ? 32'h0000_00EE : $urandom;
      cycle(v, d, r);
      total++; if (ins_ready !== model_ready()) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, ins_ready, model_ready()); end
      total++; if (outs_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, outs_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        total++; if (outs_match !== model_head()) begin bad++; $display("FAIL rand_match[%0d] got=%b exp=%b", i, outs_match, model_head()); end
      end
      total++; if (mismatch_count !== 16'(mcount)) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, mismatch_count, mcount); end
      total++; if (mismatch_seen !== mseen) begin bad++; $display("FAIL rand_seen[%0d] got=%b exp=%b", i, mismatch_seen, mseen); end
    end
  endtask

  task automatic test_saturation();
    int exp_count;
    exp_count = 0;
    s_outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_ins_valid = 1'b1;
      s_ins = 32'h0000_0000;
      @(posedge clk);
      if (exp_count < 3) exp_count++;
      @(negedge clk);
      total++; if (s_mismatch_count !== 2'(exp_count)) begin
        bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, s_mismatch_count, exp_count);
      end
    end
    s_ins_valid = 1'b0;
    total++; if (s_mismatch_seen !== 1'b1) begin bad++; $display("FAIL sat_seen got=%b exp=1", s_mismatch_seen); end
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, 32'h0000_00EE, 1'b0);
    cycle(1'b1, 32'h0000_0033, 1'b0);
    ins_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", outs_valid); end
    total++; if (mismatch_count !== 16'd0 || mismatch_seen !== 1'b0) begin
      bad++; $display("FAIL midrst_stats got count=%0d seen=%b exp count=0 seen=0", mismatch_count, mismatch_seen);
    end
    total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ins_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      total++; if (outs_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d] got=%b exp=0", i, outs_valid); end
    end
    total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%b exp=1", ins_ready); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    ins = 32'h0;
    ins_valid = 1'b0;
    outs_ready = 1'b0;
    s_ins = 32'h0;
    s_ins_valid = 1'b0;
    s_outs_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
